exe_muldiv_ctrl: RTL
====================

Name: exe_muldiv_ctrl

Overview:
Multi-cycle multiply/divide sequencer that sits beside the single-cycle EXE-stage ALU. It accepts MULT/MULTU/DIV/DIVU from the EXE stage and iterates them one bit per cycle (shift-add or restoring). Results go to HI/LO registers. It raises a pipeline stall request while a younger instruction needs the unit or HI/LO before the result is ready.

Parameters:
WIDTH, 32, operand width; the iteration count equals WIDTH.

Ports:
clk  input  1  pipeline clock, rising edge
clrn  input  1  asynchronous active-low reset
start  input  1  EXE holds a mul/div instruction; sampled only when busy=0
op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
a  input  WIDTH  operand a (multiplicand/dividend), from forwarded ea
b  input  WIDTH  operand b (multiplier/divisor), from forwarded eb
use_hilo  input  1  EXE instruction reads HI/LO (MFHI/MFLO)
flush  input  1  kill the in-flight operation (branch/exception)
busy  output  1  operation in flight
stall_req  output  1  freeze PC/IF/ID/EXE this cycle
done  output  1  one-cycle pulse; hi/lo updated
hi  output  WIDTH  product high half / remainder
lo  output  WIDTH  product low half / quotient
div_zero  output  1  last divide had b==0

Behaviour:
- Reset (clrn=0, async): state=IDLE; busy, done and div_zero are 0; hi and lo are 0; counter is 0; internal accumulators are 0.
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1 latches op, |a|, |b| (magnitudes only if op[0]=1), the sign of a, and the sign of b.
  - Counter is loaded with WIDTH-1, and the state moves to RUN on the same edge.
  - For a divide with b==0, the state goes to FIX directly, skipping RUN.
- RUN: one iteration per edge. Counter decrements; at counter==0 the next state is FIX. RUN lasts exactly WIDTH cycles.
  - Multiply: 2*WIDTH-bit shift-add on magnitudes.
  - Divide: restoring shift-subtract on magnitudes.
- FIX: one cycle, then to IDLE. On this edge hi/lo are written, done=1 for the following cycle only, and busy drops.
  - Signed multiply: negate the 2*WIDTH product if the signs differ.
  - Signed divide: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - MIN/-1 (DIV 0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0, with no special trap.
  - Divide by zero: lo=all ones, hi=a (raw), div_zero=1.
  - div_zero is cleared on the next accepted start.
- Latency: start accepted at edge 0, then done is high in the cycle after edge WIDTH+1, i.e. 33 cycles later for WIDTH=32. A divide by zero takes 2 cycles.
- busy = (state != IDLE).
- stall_req = busy & (start | use_hilo). This is combinational and has no cycle of lag.
- start while busy: ignored. The stall holds the instruction in EXE, and it is accepted in the first cycle busy=0, which is the done cycle.
- hi and lo hold their values except on the FIX edge. They never show partial results.
- flush (any state): the next state is IDLE, no done, hi/lo/div_zero unchanged. flush takes priority over start in IDLE, so nothing is accepted.
- flush and the FIX edge in the same cycle: flush wins, so no write and no done.
- Reset mid-operation: immediate return to the reset values; the operation is lost.
- Counter width is clog2(WIDTH) bits and it never wraps: RUN exits on ==0.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → done 33 cycles after accept; hi=0xFFFFFFFE, lo=0x00000001; busy=1 for exactly 33 cycles.
- MULT a=0xFFFFFFFD (-3), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0, div_zero=0.
- DIVU a=0x1234, b=0 → done after 2 cycles; lo=0xFFFFFFFF, hi=0x1234, div_zero=1.
- A second start of DIVU 100/7, issued back-to-back:
  - Its start is held by stall_req=1 while busy, then accepted in the done cycle.
  - Result: lo=14, hi=2.
  - div_zero clears on that accept.
- use_hilo=1 during RUN → stall_req=1 every cycle until the done cycle, where it is 0.
- flush at RUN cycle 10 → IDLE next cycle, no done pulse, hi/lo keep the previous values.
- Repeat the MULTU case with clrn pulsed low at RUN cycle 5 → all outputs 0 asynchronously, no done.

Source files
------------

// File: rtl/exe_muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer beside the EXE-stage ALU.
// Iterates one bit per cycle (shift-add / restoring divide) and writes HI/LO.
module exe_muldiv_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             use_hilo,
   input  logic             flush,
   output logic             busy,
   output logic             stall_req,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_zero
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t               state, state_nx;
   logic [CW-1:0]        cnt;
   logic [1:0]           op_q;
   logic                 sa_q, sb_q, dz_q;
   logic [WIDTH-1:0]     opnd;
   logic [WIDTH-1:0]     acc_hi, acc_lo;
   logic [WIDTH-1:0]     a_abs, b_abs;
   logic                 accept, b_zero, fix_wr, neg_res;
   logic [WIDTH:0]       mul_sum;
   logic [WIDTH+1:0]     div_diff;
   logic [2*WIDTH-1:0]   prod_s;
   logic [WIDTH-1:0]     quot, rem;

   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
      return ~x + WIDTH'(1);
   endfunction

   function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
      return ~x + (2*WIDTH)'(1);
   endfunction

   assign b_zero    = (b == '0);
   assign accept    = (state == IDLE) & start & ~flush;
   assign a_abs     = (op[0] & a[WIDTH-1]) ? neg_w(a) : a;
   assign b_abs     = (op[0] & b[WIDTH-1]) ? neg_w(b) : b;
   assign busy      = (state != IDLE);
   assign stall_req = busy & (start | use_hilo);
   assign fix_wr    = (state == FIX) & ~flush;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = (op[1] & b_zero) ? FIX : RUN;
         RUN:     if (cnt == '0) state_nx = FIX;
         FIX:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (flush) state_nx = IDLE;
   end

   // One iteration step: multiply adds the multiplicand when the low bit is set;
   // divide trial-subtracts the divisor from the partial remainder.
   assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
   assign div_diff = {1'b0, acc_hi, acc_lo[WIDTH-1]} - {2'b00, opnd};

   assign neg_res = op_q[0] & (sa_q ^ sb_q);
   assign prod_s  = neg_res ? neg_2w({acc_hi, acc_lo}) : {acc_hi, acc_lo};
   assign quot    = neg_res ? neg_w(acc_lo) : acc_lo;
   assign rem     = (op_q[0] & sa_q) ? neg_w(acc_hi) : acc_hi;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         cnt      <= '0;
         op_q     <= '0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         dz_q     <= 1'b0;
         opnd     <= '0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         hi       <= '0;
         lo       <= '0;
         div_zero <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= fix_wr;
         if (accept) begin
            op_q     <= op;
            sa_q     <= op[0] & a[WIDTH-1];
            sb_q     <= op[0] & b[WIDTH-1];
            dz_q     <= op[1] & b_zero;
            cnt      <= CW'(WIDTH-1);
            acc_hi   <= '0;
            div_zero <= 1'b0;
            if (op[1]) begin
               // divide by zero keeps raw a so it can be returned in HI
               acc_lo <= b_zero ? a : a_abs;
               opnd   <= b_abs;
            end else begin
               acc_lo <= b_abs;
               opnd   <= a_abs;
            end
         end else if (state == RUN) begin
            if (cnt != '0) cnt <= cnt - CW'(1);
            if (op_q[1]) begin
               if (!div_diff[WIDTH+1]) begin
                  acc_hi <= div_diff[WIDTH-1:0];
                  acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
               end else begin
                  acc_hi <= {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
                  acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
               end
            end else begin
               acc_hi <= mul_sum[WIDTH:1];
               acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
         end
         if (fix_wr) begin
            if (dz_q) begin
               hi       <= acc_lo;
               lo       <= '1;
               div_zero <= 1'b1;
            end else if (op_q[1]) begin
               hi <= rem;
               lo <= quot;
            end else begin
               {hi, lo} <= prod_s;
            end
         end
      end
   end

endmodule
